// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-requester arbiter and sequencer for the shared
// big-endian 32-bit data RAM (requester 0 = LW/SW, requester 1 = fetch/debug).
//
// Ports:
//   CLK, Reset (async, active-low)
//   Req0/We0/Addr0/WData0, Req1/We1/Addr1/WData1 : request inputs, held to Ack
//   Ack0, Ack1  : one-cycle completion pulse per requester
//   RData       : data of the last completed read (held)
//   Err         : valid with Ack, access rejected (no RAM cycle)
//   Busy        : high outside IDLE
//   mAddress, mDataIn, mRD, mWR, mDataOut : RAM side
//
// Parameters:
//   MEM_BYTES     : implemented RAM bytes, word legal if Addr+3 <= MEM_BYTES-1
//   RR_EN_DEFAULT : 1 = round-robin, 0 = fixed priority (requester 0 wins)
//
// Optional macro RAM_ALIGN_CHECK_EN: when defined, Addr[1:0] != 0 is
// rejected like an out-of-range access.

module ram_access_arbiter #(
   parameter int unsigned MEM_BYTES     = 61,
   parameter bit          RR_EN_DEFAULT = 1'b1
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Req0,
   input  logic        We0,
   input  logic [31:0] Addr0,
   input  logic [31:0] WData0,
   input  logic        Req1,
   input  logic        We1,
   input  logic [31:0] Addr1,
   input  logic [31:0] WData1,
   output logic        Ack0,
   output logic        Ack1,
   output logic [31:0] RData,
   output logic        Err,
   output logic        Busy,
   output logic [31:0] mAddress,
   output logic [31:0] mDataIn,
   output logic        mRD,
   output logic        mWR,
   input  logic [31:0] mDataOut
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Highest legal word start is LAST_BYTE-3; compared in 33 bits so that
   // addresses near 0xFFFFFFFF cannot wrap into range.
   localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

   state_t      state_q, state_d;
   logic        gnt_q, gnt_d;
   logic        we_q, we_d;
   logic        last_q, last_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] mdin_q, mdin_d;
   logic        mrd_q, mrd_d;
   logic        mwr_q, mwr_d;

   logic        req_any;
   logic        sel;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [32:0] addr_end;
   logic        in_range;
   logic        aligned;
   logic        legal;

   // Request selection. last_q holds the requester served most recently;
   // under contention round-robin picks the other one.
   always_comb begin
      req_any = Req0 | Req1;
      sel     = 1'b0;
      if (Req0 && Req1) begin
         if (RR_EN_DEFAULT) begin
            sel = ~last_q;
         end else begin
            sel = 1'b0;
         end
      end else if (Req1) begin
         sel = 1'b1;
      end
      sel_we    = sel ? We1 : We0;
      sel_addr  = sel ? Addr1 : Addr0;
      sel_wdata = sel ? WData1 : WData0;
   end

   // Legality of the selected access.
   always_comb begin
      addr_end = {1'b0, sel_addr} + 33'd3;
      in_range = (addr_end <= LAST_BYTE);
`ifdef RAM_ALIGN_CHECK_EN
      aligned  = (sel_addr[1:0] == 2'b00);
`else
      aligned  = 1'b1;
`endif
      legal    = in_range & aligned;
   end

   // Next-state and registered-output logic. Strobes and acks default
   // low so each is a single-cycle pulse in its own state.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      last_d  = last_q;
      rdata_d = rdata_q;
      maddr_d = maddr_q;
      mdin_d  = mdin_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      err_d   = 1'b0;
      mrd_d   = 1'b0;
      mwr_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_any) begin
               gnt_d   = sel;
               we_d    = sel_we;
               maddr_d = sel_addr;
               mdin_d  = sel_wdata;
               if (legal) begin
                  state_d = ACCESS;
                  mrd_d   = ~sel_we;
                  mwr_d   = sel_we;
               end else begin
                  // Rejected: skip the RAM cycle, answer next cycle.
                  state_d = RESP;
                  ack0_d  = ~sel;
                  ack1_d  = sel;
                  err_d   = 1'b1;
               end
            end
         end
         ACCESS: begin
            state_d = RESP;
            if (!we_q) begin
               rdata_d = mDataOut;
            end
            ack0_d = ~gnt_q;
            ack1_d = gnt_q;
         end
         RESP: begin
            state_d = IDLE;
            last_d  = gnt_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         // Pretend requester 1 went last so requester 0 is favoured first.
         last_q  <= 1'b1;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= 32'd0;
         maddr_q <= 32'd0;
         mdin_q  <= 32'd0;
         mrd_q   <= 1'b0;
         mwr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         last_q  <= last_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
         maddr_q <= maddr_d;
         mdin_q  <= mdin_d;
         mrd_q   <= mrd_d;
         mwr_q   <= mwr_d;
      end
   end

   assign Ack0     = ack0_q;
   assign Ack1     = ack1_q;
   assign Err      = err_q;
   assign Busy     = busy_q;
   assign RData    = rdata_q;
   assign mAddress = maddr_q;
   assign mDataIn  = mdin_q;
   assign mRD      = mrd_q;
   assign mWR      = mwr_q;

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared byte-addressed, big-endian 32-bit data RAM.
- Requester 0 is the data path (LW/SW); requester 1 is the fetch/debug path.
- Grants one request at a time and drives the RAM's Address/DataIn/mRD/mWR with registered, glitch-free strobes.
- Returns read data and a per-requester acknowledge, so the multicycle controller can stall on Ack instead of assuming fixed memory timing.

Parameters:
- MEM_BYTES, 61: number of implemented RAM bytes; a word access is legal only if Addr+3 <= MEM_BYTES-1.
- RR_EN_DEFAULT, 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Req0  in  1  requester 0 access request; held until Ack0.
- We0  in  1  requester 0: 1 = write, 0 = read.
- Addr0  in  32  requester 0 byte address.
- WData0  in  32  requester 0 write data.
- Req1, We1, Addr1, WData1  in  1/1/32/32  same meaning for requester 1.
- Ack0  out  1  one-cycle completion pulse to requester 0.
- Ack1  out  1  one-cycle completion pulse to requester 1.
- RData  out  32  read data of the completed read; valid in the Ack cycle, held until the next read completes.
- Err  out  1  valid with Ack: access rejected, no RAM cycle performed.
- Busy  out  1  high in any state except IDLE.
- mAddress  out  32  to RAM Address.
- mDataIn  out  32  to RAM DataIn.
- mRD  out  1  RAM read enable.
- mWR  out  1  RAM write enable.
- mDataOut  in  32  from RAM DataOut.

Behaviour:
- Reset (async, Reset=0), all registered:
  - State=IDLE.
  - Ack0/Ack1/Err/mRD/mWR/Busy=0.
  - RData=0, mAddress=0, mDataIn=0.
  - Round-robin pointer favours requester 0.
- Reset asserted mid-ACCESS drops mRD/mWR immediately; the interrupted request gets no Ack and is re-arbitrated after release if still held.
- State IDLE:
  - Sample Req0/Req1 at the edge.
  - Single request: grant it.
  - Both requests: RR_EN_DEFAULT=1 grants the requester not granted last; 0 grants requester 0.
  - On grant: latch id, We, Addr, WData into mAddress/mDataIn.
  - Check address range (and alignment, see Optional Feature).
  - Legal access: go ACCESS. Illegal access: go RESP with Err pending.
- State ACCESS (exactly 1 cycle):
  - mRD=~We, mWR=We; mAddress/mDataIn held stable the whole cycle.
  - On exit, a read captures mDataOut into RData.
  - Go RESP.
- State RESP (1 cycle):
  - mRD=mWR=0.
  - Ack of the granted requester=1; Err=1 if rejected, else 0.
  - Update the round-robin pointer.
  - Go IDLE.
- Latency: Req seen at edge N -> ACCESS during cycle N+1 -> Ack during cycle N+2. One access per 3 cycles.
- Requesters must drop or change Req in the Ack cycle. A Req still high in IDLE after its Ack is treated as a new request.
- Requester inputs are ignored outside IDLE. Changes to a granted request's Addr/We/WData after grant have no effect.
- mRD and mWR are never high together, and never high outside ACCESS.
- Range check uses 33-bit arithmetic: Addr+3 computed without wrap-around. Addr=0xFFFFFFFE is out of range.
- A rejected write leaves the RAM untouched. A rejected read leaves RData unchanged.

Optional Feature:
- Macro: RAM_ALIGN_CHECK_EN.
- Defined: Addr[1:0]!=0 is rejected like out-of-range: no RAM cycle, Ack with Err=1.
- Undefined: unaligned word addresses are passed to the RAM unchanged; only the range check can set Err.

Test Plan:
- Reset=0 while Req0=1 We0=1 Addr0=8 -> mWR=0, Ack0=0, Busy=0; after release, write reaches RAM with Ack0 two cycles after the first sampling edge.
- Req0 We0=1 Addr0=4 WData0=0x12345678, then Req0 We0=0 Addr0=4 -> mWR high exactly 1 cycle; read Ack0 shows RData=0x12345678, Err=0.
- Req0 and Req1 (reads) asserted together and held, RR_EN_DEFAULT=1 -> Ack order 0,1,0,1; with RR_EN_DEFAULT=0 -> requester 1 never acked while Req0 is held.
- Req1 read Addr1=58 (58+3>60) -> no mRD pulse, Ack1=1 with Err=1, RData unchanged.
- With RAM_ALIGN_CHECK_EN defined, Req0 read Addr0=6 -> Ack0 with Err=1, no mRD. Without it -> mRD pulse, Err=0.
- Change Addr0 from 4 to 12 the cycle after grant -> RAM sees mAddress=4 throughout ACCESS.
